logicnet_input_quantizer: RTL

- Upstream feeder for the layer-0 neuron LUTs.
- Accepts raw signed feature samples serially, one feature per beat, on a valid/ready stream.
- Quantizes each feature to a 2-bit code against three per-feature thresholds and assembles a full input vector.
- Presents the vector, registered, on a valid/ready output whose bits are wired straight to the layer-0 neuron fan-in buses. Assembly and output registers are double-buffered so collection of sample k+1 overlaps consumption of sample k.

---
 rtl/logicnet_input_quantizer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/logicnet_input_quantizer.sv
// logicnet_input_quantizer
// Collects signed raw features one beat at a time, quantizes each to a 2-bit
// code against three per-feature thresholds and emits the assembled vector on
// a registered valid/ready output. The assembly register doubles as a second
// buffer: a finished vector can wait in it (HOLD) while the previous vector
// is still presented on the output.
//
// state   | meaning
// COLLECT | accepting features into the assembly register
// HOLD    | assembly holds a finished vector, waiting for the output register
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     input feature handshake
//   s_data, s_last      signed feature value, final-feature marker
//   m_valid/m_ready     output vector handshake
//   m_data              quantized vector, feature i at [2i+1:2i]
//   frame_err           one-cycle pulse after a framing error
//   sample_cnt          vectors emitted (wraps)
//   drop_cnt            samples dropped on framing errors (saturates)
module logicnet_input_quantizer #(
   parameter int NUM_FEATURES = 16,
   parameter int IN_W         = 16,
   parameter logic [NUM_FEATURES*3*IN_W-1:0] THRESH = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic signed [IN_W-1:0]      s_data,
   input  logic                        s_last,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [2*NUM_FEATURES-1:0]   m_data,
   output logic                        frame_err,
   output logic [15:0]                 sample_cnt,
   output logic [7:0]                  drop_cnt
);

   localparam int IDX_W = $clog2(NUM_FEATURES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [2*NUM_FEATURES-1:0] asm_q, asm_d;
   logic [2*NUM_FEATURES-1:0] m_data_q, m_data_d;
   logic                      m_valid_q, m_valid_d;
   logic                      frame_err_q, frame_err_d;
   logic [15:0]               sample_cnt_q, sample_cnt_d;
   logic [7:0]                drop_cnt_q, drop_cnt_d;
   // Held low through reset so s_ready rises only after release.
   logic                      alive_q;

   logic signed [IN_W-1:0] thr0 [NUM_FEATURES];
   logic signed [IN_W-1:0] thr1 [NUM_FEATURES];
   logic signed [IN_W-1:0] thr2 [NUM_FEATURES];

   for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_thr
      assign thr0[g] = THRESH[(3*g+0)*IN_W +: IN_W];
      assign thr1[g] = THRESH[(3*g+1)*IN_W +: IN_W];
      assign thr2[g] = THRESH[(3*g+2)*IN_W +: IN_W];
   end

   logic                      accept;
   logic                      out_hs;
   logic                      out_free;
   logic [1:0]                code;
   logic [2*NUM_FEATURES-1:0] vec_full;

   assign s_ready  = alive_q && (state_q == COLLECT);
   assign accept   = s_valid && s_ready;
   assign out_hs   = m_valid_q && m_ready;
   assign out_free = !m_valid_q || m_ready;

   // Highest threshold checked first so equal thresholds collapse codes.
   always_comb begin
      code = 2'd0;
      if (s_data >= thr2[idx_q])      code = 2'd3;
      else if (s_data >= thr1[idx_q]) code = 2'd2;
      else if (s_data >= thr0[idx_q]) code = 2'd1;
   end

   always_comb begin
      vec_full = asm_q;
      vec_full[2*idx_q +: 2] = code;
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      asm_d        = asm_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      frame_err_d  = 1'b0;
      sample_cnt_d = sample_cnt_q;
      drop_cnt_d   = drop_cnt_q;

      if (out_hs) m_valid_d = 1'b0;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (s_last != (idx_q == LAST_IDX)) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
                  asm_d       = '0;
                  if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
               end else if (s_last) begin
                  idx_d = '0;
                  if (out_free) begin
                     m_data_d     = vec_full;
                     m_valid_d    = 1'b1;
                     sample_cnt_d = sample_cnt_q + 16'd1;
                     asm_d        = '0;
                  end else begin
                     asm_d   = vec_full;
                     state_d = HOLD;
                  end
               end else begin
                  asm_d = vec_full;
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_hs) begin
               m_data_d     = asm_q;
               m_valid_d    = 1'b1;
               sample_cnt_d = sample_cnt_q + 16'd1;
               asm_d        = '0;
               state_d      = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         idx_q        <= '0;
         asm_q        <= '0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         sample_cnt_q <= '0;
         drop_cnt_q   <= '0;
         alive_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         frame_err_q  <= frame_err_d;
         sample_cnt_q <= sample_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         alive_q      <= 1'b1;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign frame_err  = frame_err_q;
   assign sample_cnt = sample_cnt_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
